// File: rtl/neuron_spike_gen_if.sv
// neuron_spike_gen_if
// Bundles the synaptic input and spike/latch-control outputs of the
// leaky integrate-and-fire spike generator.
//
// Signals:
//   synIn     - synaptic event valid this cycle        (master -> slave)
//   weight    - signed synaptic weight, WEIGHT_W bits  (master -> slave)
//   dataOut   - registered spike level, to latch dataIn (slave -> master)
//   crit      - registered latch hold strobe (1 = hold) (slave -> master)
//   potential - membrane potential, WIDTH bits, debug   (slave -> master)
//
// Modports:
//   master - the event source / observer
//   slave  - the neuron itself
interface neuron_spike_gen_if #(
    parameter int WIDTH    = 8,
    parameter int WEIGHT_W = 8
) ();

    logic                       synIn;
    logic signed [WEIGHT_W-1:0] weight;
    logic                       dataOut;
    logic                       crit;
    logic [WIDTH-1:0]           potential;

    modport master (
        output synIn,
        output weight,
        input  dataOut,
        input  crit,
        input  potential
    );

    modport slave (
        input  synIn,
        input  weight,
        output dataOut,
        output crit,
        output potential
    );

endinterface

// File: rtl/neuron_spike_gen.sv
// neuron_spike_gen
// Leaky integrate-and-fire spike generator feeding the spike-capture
// D-latch. Weighted synaptic events are integrated into a saturating
// membrane potential; crossing THRESHOLD launches a spike whose rise and
// fall are bracketed by the latch hold strobe (crit), so dataOut only
// changes while the latch is holding.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   io_bus - neuron_spike_gen_if.slave (synIn, weight in; dataOut, crit,
//            potential out; all outputs registered)
//
// Parameters: WIDTH, WEIGHT_W, THRESHOLD, LEAK, REFRACT
//
// Configuration macro: NEURON_SPIKE_LEAK_EN
//   defined   - LEAK is subtracted every integrate cycle
//   undefined - pure saturating integrator; LEAK has no effect
module neuron_spike_gen #(
    parameter int WIDTH     = 8,
    parameter int WEIGHT_W  = 8,
    parameter int THRESHOLD = 100,
    parameter int LEAK      = 1,
    parameter int REFRACT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    neuron_spike_gen_if.slave  io_bus
);

    localparam int SW = WIDTH + WEIGHT_W + 1;
    localparam int CW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

    localparam logic signed [SW-1:0] MAX_POT =
        {{(WEIGHT_W + 1){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] THRESH   = WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(REFRACT);

`ifdef NEURON_SPIKE_LEAK_EN
    localparam logic signed [SW-1:0] LEAK_TERM = SW'(LEAK);
`else
    // The parameter is still accepted but contributes nothing.
    localparam logic signed [SW-1:0] LEAK_TERM = SW'(LEAK * 0);
`endif

    typedef enum logic [2:0] {
        S_INTEGRATE,
        S_ARM_RISE,
        S_RISE,
        S_REFRACT,
        S_ARM_FALL,
        S_FALL
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_potential;
    logic [CW-1:0]    r_count;
    logic             r_crit;
    logic             r_dataOut;

    state_t                  w_nextState;
    logic [WIDTH-1:0]        w_nextPot;
    logic [CW-1:0]           w_nextCount;
    logic                    w_nextCrit;
    logic                    w_nextData;
    logic signed [SW-1:0]    w_potExt;
    logic signed [SW-1:0]    w_weightExt;
    logic signed [SW-1:0]    w_sum;
    logic [WIDTH-1:0]        w_clamped;

    // Integrator datapath: the sum is formed wide enough that neither the
    // add nor the leak subtraction can overflow, then saturated back into
    // WIDTH bits so the potential never wraps in either direction.
    always_comb begin
        w_potExt    = {{(WEIGHT_W + 1){1'b0}}, r_potential};
        w_weightExt = '0;
        if (io_bus.synIn) begin
            w_weightExt = {{(WIDTH + 1){io_bus.weight[WEIGHT_W-1]}}, io_bus.weight};
        end
        w_sum = w_potExt + w_weightExt - LEAK_TERM;
        if (w_sum[SW-1]) begin
            w_clamped = '0;
        end else if (w_sum > MAX_POT) begin
            w_clamped = {WIDTH{1'b1}};
        end else begin
            w_clamped = w_sum[WIDTH-1:0];
        end
    end

    // Spike sequencer. The output levels are decoded from the next state
    // and registered, so crit/dataOut are true flops with no input path.
    // The potential is cleared on the edge that enters RISE so it reads 0
    // together with the first high cycle of dataOut. The refractory count
    // is loaded on the edge into REFRACT, giving exactly REFRACT cycles of
    // crit low (latch transparent) while the spike is high.
    always_comb begin
        w_nextState = r_state;
        w_nextPot   = r_potential;
        w_nextCount = r_count;
        w_nextCrit  = 1'b0;
        w_nextData  = 1'b0;

        case (r_state)
            S_INTEGRATE: begin
                w_nextPot = w_clamped;
                if (w_clamped >= THRESH) begin
                    w_nextState = S_ARM_RISE;
                end
            end
            S_ARM_RISE: begin
                w_nextPot   = '0;
                w_nextState = S_RISE;
            end
            S_RISE: begin
                w_nextCount = CNT_LOAD;
                w_nextState = S_REFRACT;
            end
            S_REFRACT: begin
                w_nextCount = r_count - CW'(1);
                if (r_count <= CW'(1)) begin
                    w_nextState = S_ARM_FALL;
                end
            end
            S_ARM_FALL: begin
                w_nextState = S_FALL;
            end
            S_FALL: begin
                w_nextState = S_INTEGRATE;
            end
            default: begin
                w_nextState = S_INTEGRATE;
            end
        endcase

        case (w_nextState)
            S_ARM_RISE: begin
                w_nextCrit = 1'b1;
                w_nextData = 1'b0;
            end
            S_RISE: begin
                w_nextCrit = 1'b1;
                w_nextData = 1'b1;
            end
            S_REFRACT: begin
                w_nextCrit = 1'b0;
                w_nextData = 1'b1;
            end
            S_ARM_FALL: begin
                w_nextCrit = 1'b1;
                w_nextData = 1'b1;
            end
            S_FALL: begin
                w_nextCrit = 1'b1;
                w_nextData = 1'b0;
            end
            default: begin
                w_nextCrit = 1'b0;
                w_nextData = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once so the
    // latch sees a quiet, transparent-low input regardless of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INTEGRATE;
            r_potential <= '0;
            r_count     <= '0;
            r_crit      <= 1'b0;
            r_dataOut   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_potential <= w_nextPot;
            r_count     <= w_nextCount;
            r_crit      <= w_nextCrit;
            r_dataOut   <= w_nextData;
        end
    end

    assign io_bus.dataOut   = r_dataOut;
    assign io_bus.crit      = r_crit;
    assign io_bus.potential = r_potential;

endmodule
